msgpass_buff_addr_gen: RTL and testbench
========================================

MSGPASS_BUFF_ADDR_GEN -- requirements
Module: msgpass_buff_addr_gen

Interface
REQ-001 SHALL have parameter MSGPASS_BUFF_ADDR_WIDTH, default 7: buffer address width; DEPTH = 2**MSGPASS_BUFF_ADDR_WIDTH.
REQ-002 SHALL have parameter INCREMENT_SRC_NUM, default 4: number of selectable stride sources.
REQ-003 SHALL have parameter INCREMENT_SRC_SEL_WIDTH, default $clog2(INCREMENT_SRC_NUM): stride-select width.
REQ-004 SHALL have parameter STRIDE_WIDTH, default 4: width of each stride.
REQ-005 SHALL have parameter BEAT_CNT_WIDTH, default 8: width of the beat count.
REQ-006 SHALL use one clock and an asynchronous, active-low reset; all state changes on the rising sys_clk edge.
REQ-007 Ports:
- sys_clk  in  1  clock
- rstn  in  1  async active-low reset
- start_i  in  1  start request, honoured only in IDLE
- base_addr_i  in  MSGPASS_BUFF_ADDR_WIDTH  window base address
- win_size_i  in  MSGPASS_BUFF_ADDR_WIDTH+1  window size, legal range 1..DEPTH
- beat_num_i  in  BEAT_CNT_WIDTH  number of addresses to emit
- incr_src_i  in  INCREMENT_SRC_NUM*STRIDE_WIDTH  packed strides; source k at bits [k*STRIDE_WIDTH +: STRIDE_WIDTH]
- incr_sel_i  in  INCREMENT_SRC_SEL_WIDTH  stride select, sampled at each handshake
- addr_o  out  MSGPASS_BUFF_ADDR_WIDTH  generated address
- addr_valid_o  out  1  addr_o valid
- addr_ready_i  in  1  consumer accepts addr_o
- busy_o  out  1  state is not IDLE
- done_o  out  1  single-cycle completion pulse
- cfg_err_o  out  1  single-cycle configuration-error pulse

Function
REQ-008 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-009 IDLE + start_i with beat_num_i != 0: SHALL latch base, window, beat count and all strides; zero the offset; enter RUN.
REQ-010 IDLE + start_i with beat_num_i == 0: SHALL enter DONE directly; no address emitted.
REQ-011 In RUN: addr_valid_o = 1; addr_o = (base + offset) mod DEPTH; the physical buffer wraps at DEPTH.
REQ-012 addr_o SHALL hold stable while addr_valid_o = 1 and addr_ready_i = 0.
REQ-013 Handshake (addr_valid_o & addr_ready_i), when it is not the last beat: offset_next = offset + stride[incr_sel_i]; subtract win_size once if the result is >= win_size; decrement the remaining count.
REQ-014 Handshake on the last beat (remaining == 1): SHALL enter DONE; addr_valid_o deasserts the next cycle.
REQ-015 Throughput SHALL be one address per cycle while addr_ready_i = 1; first address is valid the cycle after start is accepted.
REQ-016 DONE: done_o = 1 for exactly one cycle, then IDLE; busy_o = 1 in RUN and DONE.
REQ-017 start_i outside IDLE SHALL be ignored; latched configuration is unaffected by input changes during RUN.
REQ-018 Offset arithmetic SHALL be at least MSGPASS_BUFF_ADDR_WIDTH+2 bits wide; no overflow for any legal stride < win_size.

Reset
REQ-019 rstn low SHALL immediately force IDLE with addr_o = 0, addr_valid_o = 0, busy_o = 0, done_o = 0, cfg_err_o = 0, and all counters and latched configuration cleared; no done_o pulse on abort.
REQ-020 Reset asserted mid-RUN SHALL abort the sequence; the first start_i after deassertion begins a fresh sequence.

Configuration
REQ-021 Macro MSGPASS_ADDR_GEN_CHK_EN defined: on start_i in IDLE with win_size_i == 0 or win_size_i > DEPTH, SHALL pulse cfg_err_o for one cycle and remain in IDLE.
REQ-022 Macro MSGPASS_ADDR_GEN_CHK_EN defined: on a non-last handshake with stride[incr_sel_i] >= win_size, SHALL pulse cfg_err_o and enter DONE; done_o pulses as normal.
REQ-023 Macro not defined: cfg_err_o tied to 0, no checks; win_size_i == 0 is treated as DEPTH; out-of-range strides give an unspecified address but the beat count and FSM are unaffected.

Verification
REQ-024 base=10, win=8, beats=5, stride0=3, sel=0, ready=1 -> addr 10,13,16,11,14 on consecutive cycles; done_o pulses once.
REQ-025 base=126, win=4, beats=4, stride=1 -> addr 126,127,0,1 (DEPTH wrap); busy_o = 1 throughout.
REQ-026 Same as REQ-024 but ready low for 3 cycles on beat 2 -> addr_o holds 13 stable; sequence and beat count unchanged.
REQ-027 sel alternates 0/1 with stride0=1, stride1=2, base=0, win=16, beats=4 -> addr 0,1,3,4.
REQ-028 beats=0 start -> no addr_valid_o; done_o the next cycle. With CHK_EN: win=0 start -> cfg_err_o pulse, busy_o stays 0.
REQ-029 rstn low during beat 3 of REQ-024 -> all outputs 0, no done_o; a new start after reset restarts at addr 10.

Source files
------------

// File: rtl/msgpass_buff_addr_gen.sv
// Windowed ring-buffer address generator with selectable per-beat stride.
// Optional configuration checks enabled by defining MSGPASS_ADDR_GEN_CHK_EN.
module msgpass_buff_addr_gen #(
    parameter int MSGPASS_BUFF_ADDR_WIDTH = 7,
    parameter int INCREMENT_SRC_NUM       = 4,
    parameter int INCREMENT_SRC_SEL_WIDTH = $clog2(INCREMENT_SRC_NUM),
    parameter int STRIDE_WIDTH            = 4,
    parameter int BEAT_CNT_WIDTH          = 8
) (
    input  logic                                        sys_clk,
    input  logic                                        rstn,
    input  logic                                        start_i,
    input  logic [MSGPASS_BUFF_ADDR_WIDTH-1:0]          base_addr_i,
    input  logic [MSGPASS_BUFF_ADDR_WIDTH:0]            win_size_i,
    input  logic [BEAT_CNT_WIDTH-1:0]                   beat_num_i,
    input  logic [INCREMENT_SRC_NUM*STRIDE_WIDTH-1:0]   incr_src_i,
    input  logic [INCREMENT_SRC_SEL_WIDTH-1:0]          incr_sel_i,
    output logic [MSGPASS_BUFF_ADDR_WIDTH-1:0]          addr_o,
    output logic                                        addr_valid_o,
    input  logic                                        addr_ready_i,
    output logic                                        busy_o,
    output logic                                        done_o,
    output logic                                        cfg_err_o
);

    localparam int AW = MSGPASS_BUFF_ADDR_WIDTH;
    localparam int OW = MSGPASS_BUFF_ADDR_WIDTH + 2;
    localparam int BW = BEAT_CNT_WIDTH;
    localparam int SW = STRIDE_WIDTH;
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

`ifdef MSGPASS_ADDR_GEN_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]                       state_q;
    logic [AW-1:0]                    base_q;
    logic [AW:0]                      win_q;
    logic [BW-1:0]                    cnt_q;
    logic [OW-1:0]                    off_q;
    logic [INCREMENT_SRC_NUM*SW-1:0]  stride_q;
    logic                             cfg_err_q;

    logic [SW-1:0]   stride_sel;
    logic [OW-1:0]   off_sum;
    logic [OW-1:0]   off_next;
    logic [AW:0]     win_eff;
    logic            handshake;
    logic            last_beat;
    logic            win_bad;
    logic            stride_bad;

    always_comb begin
        stride_sel = stride_q[incr_sel_i*SW +: SW];
        off_sum    = off_q + OW'(stride_sel);
        // Single conditional subtract suffices because offset < win and stride < win.
        off_next   = (off_sum >= OW'(win_q)) ? off_sum - OW'(win_q) : off_sum;
        win_eff    = (win_size_i == '0) ? DEPTH : win_size_i;
        handshake  = (state_q == RUN) && addr_ready_i;
        last_beat  = (cnt_q == BW'(1));
        win_bad    = CHK_EN && ((win_size_i == '0) || (win_size_i > DEPTH));
        stride_bad = CHK_EN && (OW'(stride_sel) >= OW'(win_q));
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            base_q    <= '0;
            win_q     <= '0;
            cnt_q     <= '0;
            off_q     <= '0;
            stride_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (win_bad) begin
                            cfg_err_q <= 1'b1;
                        end else if (beat_num_i == '0) begin
                            state_q <= DONE;
                        end else begin
                            base_q   <= base_addr_i;
                            win_q    <= win_eff;
                            cnt_q    <= beat_num_i;
                            stride_q <= incr_src_i;
                            off_q    <= '0;
                            state_q  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (handshake) begin
                        if (last_beat) begin
                            state_q <= DONE;
                        end else if (stride_bad) begin
                            cfg_err_q <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            off_q <= off_next;
                            cnt_q <= cnt_q - BW'(1);
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign addr_valid_o = (state_q == RUN);
    assign addr_o       = (state_q == RUN) ? (base_q + off_q[AW-1:0]) : '0;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign cfg_err_o    = cfg_err_q;

endmodule

// File: tb/tb_msgpass_buff_addr_gen.sv
// Randomized and directed bench for msgpass_buff_addr_gen against a modulo-arithmetic model.
// Extra checks run when MSGPASS_ADDR_GEN_CHK_EN is defined.
module tb_msgpass_buff_addr_gen;

    localparam int DEPTH = 128;

    logic        sys_clk = 1'b0;
    logic        rstn;
    logic        start_i;
    logic [6:0]  base_addr_i;
    logic [7:0]  win_size_i;
    logic [7:0]  beat_num_i;
    logic [15:0] incr_src_i;
    logic [1:0]  incr_sel_i;
    logic [6:0]  addr_o;
    logic        addr_valid_o;
    logic        addr_ready_i;
    logic        busy_o;
    logic        done_o;
    logic        cfg_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] strides_pk;
    int          sel_arr [256];

    msgpass_buff_addr_gen dut (
        .sys_clk      (sys_clk),
        .rstn         (rstn),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .win_size_i   (win_size_i),
        .beat_num_i   (beat_num_i),
        .incr_src_i   (incr_src_i),
        .incr_sel_i   (incr_sel_i),
        .addr_o       (addr_o),
        .addr_valid_o (addr_valid_o),
        .addr_ready_i (addr_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .cfg_err_o    (cfg_err_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic int stride_of(input logic [15:0] pk, input int s);
        return int'((pk >> (s * 4)) & 16'hF);
    endfunction

    // mode: 0 always ready, 1 random ready, 2 three-cycle stall on second beat
    task automatic run_seq(input int base, input int win, input int beats,
                           input int mode, input int abort_at);
        int exp_addr[$];
        int off;
        int weff;
        int i;
        int cyc;
        int stall;
        int budget;
        logic rdy;
        weff = (win == 0) ? DEPTH : win;
        off  = 0;
        for (int k = 0; k < beats; k++) begin
            exp_addr.push_back((base + off) % DEPTH);
            off = (off + stride_of(strides_pk, sel_arr[k])) % weff;
        end

        base_addr_i = 7'(base);
        win_size_i  = 8'(win);
        beat_num_i  = 8'(beats);
        incr_src_i  = strides_pk;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
        base_addr_i = 7'($urandom);
        win_size_i  = 8'($urandom);
        beat_num_i  = 8'($urandom);
        incr_src_i  = 16'($urandom);

        if (beats == 0) begin
            check_val("zero_valid", int'(addr_valid_o), 0);
            check_val("zero_done", int'(done_o), 1);
            tick();
            check_val("zero_done_end", int'(done_o), 0);
            check_val("zero_busy_end", int'(busy_o), 0);
            return;
        end

        i = 0; cyc = 0; stall = 0;
        budget = beats * 8 + 20;
        while (i < beats && cyc < budget) begin
            check_val("valid", int'(addr_valid_o), 1);
            check_val("addr", int'(addr_o), exp_addr[i]);
            check_val("busy_run", int'(busy_o), 1);
            check_val("done_run", int'(done_o), 0);
            check_val("cfg_err_run", int'(cfg_err_o), 0);
            if (i == abort_at) begin
                rstn = 1'b0;
                #1;
                check_val("abort_addr", int'(addr_o), 0);
                check_val("abort_valid", int'(addr_valid_o), 0);
                check_val("abort_busy", int'(busy_o), 0);
                check_val("abort_done", int'(done_o), 0);
                check_val("abort_cfg_err", int'(cfg_err_o), 0);
                tick();
                check_val("abort_done2", int'(done_o), 0);
                rstn = 1'b1;
                tick();
                check_val("abort_done3", int'(done_o), 0);
                check_val("abort_busy3", int'(busy_o), 0);
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    if (i == 1 && stall < 3) begin
                        rdy = 1'b0;
                        stall++;
                    end else begin
                        rdy = 1'b1;
                    end
                end
            endcase
            addr_ready_i = rdy;
            incr_sel_i   = rdy ? 2'(sel_arr[i]) : 2'($urandom);
            start_i      = 1'($urandom_range(0, 1));
            tick();
            cyc++;
            if (rdy) i++;
        end
        start_i = 1'b0;
        addr_ready_i = 1'($urandom_range(0, 1));
        if (i < beats) check_val("timeout", 1, 0);
        check_val("end_valid", int'(addr_valid_o), 0);
        check_val("end_done", int'(done_o), 1);
        check_val("end_busy", int'(busy_o), 1);
        tick();
        check_val("idle_done", int'(done_o), 0);
        check_val("idle_busy", int'(busy_o), 0);
        check_val("idle_valid", int'(addr_valid_o), 0);
    endtask

    initial begin
        int b, w, n, lim;
        rstn = 1'b0; start_i = 1'b0; base_addr_i = '0; win_size_i = '0;
        beat_num_i = '0; incr_src_i = '0; incr_sel_i = '0; addr_ready_i = 1'b0;
        strides_pk = '0;
        tick(); tick();
        check_val("rst_addr", int'(addr_o), 0);
        check_val("rst_valid", int'(addr_valid_o), 0);
        check_val("rst_busy", int'(busy_o), 0);
        check_val("rst_done", int'(done_o), 0);
        check_val("rst_cfg_err", int'(cfg_err_o), 0);
        rstn = 1'b1;
        tick();

        // base 10, win 8, stride0 3
        strides_pk = 16'h0003;
        for (int k = 0; k < 256; k++) sel_arr[k] = 0;
        run_seq(10, 8, 5, 0, -1);
        // buffer wrap at DEPTH
        strides_pk = 16'h0001;
        run_seq(126, 4, 4, 0, -1);
        // stall on beat 2
        strides_pk = 16'h0003;
        run_seq(10, 8, 5, 2, -1);
        // alternating selects
        strides_pk = 16'h0021;
        for (int k = 0; k < 4; k++) sel_arr[k] = k % 2;
        run_seq(0, 16, 4, 0, -1);
        // zero beats
        run_seq(3, 8, 0, 0, -1);
        // reset during beat 3 then restart
        strides_pk = 16'h0003;
        for (int k = 0; k < 256; k++) sel_arr[k] = 0;
        run_seq(10, 8, 5, 0, 2);
        run_seq(10, 8, 5, 0, -1);
`ifndef MSGPASS_ADDR_GEN_CHK_EN
        strides_pk = 16'h7F5D;
        for (int k = 0; k < 6; k++) sel_arr[k] = k % 4;
        run_seq(5, 0, 6, 0, -1);
`endif

        for (int t = 0; t < 40; t++) begin
            b = $urandom_range(0, DEPTH - 1);
            w = $urandom_range(1, DEPTH);
            n = $urandom_range(0, 20);
            lim = (w - 1 < 15) ? w - 1 : 15;
            for (int s = 0; s < 4; s++) strides_pk[s*4 +: 4] = 4'($urandom_range(0, lim));
            for (int k = 0; k < n; k++) sel_arr[k] = $urandom_range(0, 3);
            run_seq(b, w, n, 1, -1);
        end

`ifdef MSGPASS_ADDR_GEN_CHK_EN
        for (int c = 0; c < 2; c++) begin
            win_size_i = (c == 0) ? 8'd0 : 8'd129;
            beat_num_i = 8'd4;
            start_i    = 1'b1;
            tick();
            start_i    = 1'b0;
            check_val("chk_cfg_err", int'(cfg_err_o), 1);
            check_val("chk_busy", int'(busy_o), 0);
            tick();
            check_val("chk_cfg_err_end", int'(cfg_err_o), 0);
            check_val("chk_busy_end", int'(busy_o), 0);
            check_val("chk_done_end", int'(done_o), 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
